// File: rtl/ram_arb_pkg.sv
// Shared constants for the core/keyboard RAM port arbiter: FSM encoding,
// port identities and the legal read-latency window.
package ram_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic OWNER_C = 1'b0;
  localparam logic OWNER_K = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// whichever port did not own the RAM last.
module arb_rr2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       sel,
  output logic       any
);

  always_comb begin
    any = |req;
    if (req == 2'b11) begin
      sel = ~last_owner;
    end else begin
      sel = req[OWNER_K];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between the CPU load/store path (C)
// and the keyboard scancode writer (K), one access at a time.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              k_req,
  input  logic              k_we,
  input  logic [ADDR_W-1:0] k_addr,
  input  logic [DATA_W-1:0] k_wdata,
  output logic              k_done,
  output logic [DATA_W-1:0] k_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_check
    $error("ram_port_arbiter: RD_LAT must lie in 1..4");
  end

  // Cycles still to wait after the grant cycle before read data is sampled.
  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  logic [1:0]        state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              we_reg, we_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic              ram_en_reg, ram_en_next;
  logic              ram_we_reg, ram_we_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
  logic              busy_reg, busy_next;
  logic [1:0]        done_next;
  logic              capture;
  logic              sel;
  logic              any;

  arb_rr2 u_rr (
    .req        ({k_req, c_req}),
    .last_owner (owner_reg),
    .sel        (sel),
    .any        (any)
  );

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    we_next        = we_reg;
    cnt_next       = cnt_reg;
    ram_en_next    = 1'b0;
    ram_we_next    = 1'b0;
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = ram_wdata_reg;
    done_next      = 2'b00;
    capture        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any) begin
          state_next     = GRANT;
          owner_next     = sel;
          we_next        = sel ? k_we : c_we;
          ram_addr_next  = sel ? k_addr : c_addr;
          ram_wdata_next = sel ? k_wdata : c_wdata;
          ram_en_next    = 1'b1;
          ram_we_next    = we_next;
        end
      end
      GRANT: begin
        if (we_reg) begin
          state_next           = DONE;
          done_next[owner_reg] = 1'b1;
        end else begin
          cnt_next = CNT_LOAD;
          if (RD_LAT == 1) begin
            state_next           = DONE;
            done_next[owner_reg] = 1'b1;
            capture              = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 2'd1;
        // Data is sampled on the edge that takes the counter to zero.
        if (cnt_reg == 2'd1) begin
          state_next           = DONE;
          done_next[owner_reg] = 1'b1;
          capture              = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      owner_reg     <= OWNER_K;
      we_reg        <= 1'b0;
      cnt_reg       <= 2'd0;
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      we_reg        <= we_next;
      cnt_reg       <= cnt_next;
      ram_en_reg    <= ram_en_next;
      ram_we_reg    <= ram_we_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
      busy_reg      <= busy_next;
    end
  end

  // Per-port completion pulse and read-data holding register.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_port
    logic              done_reg;
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        done_reg  <= 1'b0;
        rdata_reg <= '0;
      end else begin
        done_reg <= done_next[gi];
        if (capture && (owner_reg == 1'(gi))) begin
          rdata_reg <= ram_rdata;
        end
      end
    end
  end

  assign c_done    = g_port[0].done_reg;
  assign c_rdata   = g_port[0].rdata_reg;
  assign k_done    = g_port[1].done_reg;
  assign k_rdata   = g_port[1].rdata_reg;
  assign ram_en    = ram_en_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign busy      = busy_reg;
  assign owner     = owner_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: instance 0 runs RD_LAT = 1 and
// instance 1 runs RD_LAT = 3, each with its own behavioural RAM.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        c_req [2];
  logic        c_we [2];
  logic [15:0] c_addr [2];
  logic [15:0] c_wdata [2];
  logic        c_done [2];
  logic [15:0] c_rdata [2];
  logic        k_req [2];
  logic        k_we [2];
  logic [15:0] k_addr [2];
  logic [15:0] k_wdata [2];
  logic        k_done [2];
  logic [15:0] k_rdata [2];
  logic        ram_en [2];
  logic        ram_we [2];
  logic [15:0] ram_addr [2];
  logic [15:0] ram_wdata [2];
  logic [15:0] ram_rdata [2];
  logic        busy [2];
  logic        owner [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [15:0] mem [256];

    always @(posedge clk) begin
      if (ram_en[gi] && ram_we[gi]) mem[ram_addr[gi][7:0]] <= ram_wdata[gi];
    end

    // Read data is presented during cycle g+LAT-1 and is junk otherwise.
    if (LAT == 1) begin : g_l1
      assign ram_rdata[gi] = ram_en[gi] ? mem[ram_addr[gi][7:0]] : 16'hDEAD;
    end else begin : g_ln
      logic [15:0] pipe0, pipe1;
      always @(posedge clk) begin
        pipe0 <= ram_en[gi] ? mem[ram_addr[gi][7:0]] : 16'hDEAD;
        pipe1 <= pipe0;
      end
      assign ram_rdata[gi] = pipe1;
    end

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) dut (
      .CLOCK_50  (clk),
      .RESET_N   (rst_n),
      .c_req     (c_req[gi]),
      .c_we      (c_we[gi]),
      .c_addr    (c_addr[gi]),
      .c_wdata   (c_wdata[gi]),
      .c_done    (c_done[gi]),
      .c_rdata   (c_rdata[gi]),
      .k_req     (k_req[gi]),
      .k_we      (k_we[gi]),
      .k_addr    (k_addr[gi]),
      .k_wdata   (k_wdata[gi]),
      .k_done    (k_done[gi]),
      .k_rdata   (k_rdata[gi]),
      .ram_en    (ram_en[gi]),
      .ram_we    (ram_we[gi]),
      .ram_addr  (ram_addr[gi]),
      .ram_wdata (ram_wdata[gi]),
      .ram_rdata (ram_rdata[gi]),
      .busy      (busy[gi]),
      .owner     (owner[gi])
    );
  end

  // Drives one request on instance i, port (0 = C, 1 = K), records what happens
  // up to the done pulse, drops req, and returns in the following IDLE cycle.
  task automatic run_txn(input int i, input bit port, input bit we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         output int r, output int g, output int d, output int en_cnt,
                         output bit other_done, output logic [15:0] ea,
                         output logic [15:0] ew, output bit ewe,
                         output logic [15:0] rd, output bit other_rd_moved);
    logic [15:0] other0;
    r = cyc; g = -1; d = -1; en_cnt = 0; other_done = 0; other_rd_moved = 0;
    ea = '0; ew = '0; ewe = 0; rd = '0;
    other0 = port ? c_rdata[i] : k_rdata[i];
    if (!port) begin
      c_req[i] = 1'b1; c_we[i] = we; c_addr[i] = addr; c_wdata[i] = wdata;
    end else begin
      k_req[i] = 1'b1; k_we[i] = we; k_addr[i] = addr; k_wdata[i] = wdata;
    end
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      if ((port ? c_rdata[i] : k_rdata[i]) !== other0) other_rd_moved = 1;
      if (ram_en[i]) begin
        en_cnt++;
        if (g < 0) begin
          g = cyc; ea = ram_addr[i]; ew = ram_wdata[i]; ewe = ram_we[i];
        end
      end
      if (port ? c_done[i] : k_done[i]) other_done = 1;
      if (port ? k_done[i] : c_done[i]) begin
        d = cyc; rd = port ? k_rdata[i] : c_rdata[i];
        break;
      end
    end
    if (!port) c_req[i] = 1'b0; else k_req[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ram_en[i] !== 1'b0 || ram_we[i] !== 1'b0) begin
        errors++; $display("FAIL rst_ram_ctl[%0d]: got en=%b we=%b need 0 0", i, ram_en[i], ram_we[i]);
      end
      checks++;
      if (ram_addr[i] !== 16'h0 || ram_wdata[i] !== 16'h0) begin
        errors++; $display("FAIL rst_ram_bus[%0d]: got %h/%h need 0000/0000", i, ram_addr[i], ram_wdata[i]);
      end
      checks++;
      if (busy[i] !== 1'b0 || owner[i] !== 1'b1) begin
        errors++; $display("FAIL rst_busy_owner[%0d]: got %b %b need 0 1", i, busy[i], owner[i]);
      end
      checks++;
      if (c_done[i] !== 1'b0 || k_done[i] !== 1'b0 || c_rdata[i] !== 16'h0 || k_rdata[i] !== 16'h0) begin
        errors++; $display("FAIL rst_port_out[%0d]: got %b %b %h %h need 0 0 0000 0000",
                           i, c_done[i], k_done[i], c_rdata[i], k_rdata[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_core_write();
    int r, g, d, en; bit od, ewe, mv; logic [15:0] ea, ew, rd;
    run_txn(0, 0, 1, 16'h0010, 16'hBEEF, r, g, d, en, od, ea, ew, ewe, rd, mv);
    checks++;
    if (g !== r + 1) begin errors++; $display("FAIL wr_grant_cycle: got %0d need %0d", g - r, 1); end
    checks++;
    if (ea !== 16'h0010 || ew !== 16'hBEEF || ewe !== 1'b1) begin
      errors++; $display("FAIL wr_ram_bus: got %h %h we=%b need 0010 beef we=1", ea, ew, ewe);
    end
    checks++;
    if (d !== g + 1) begin errors++; $display("FAIL wr_done_cycle: got g+%0d need g+1", d - g); end
    checks++;
    if (od !== 1'b0 || en !== 1) begin
      errors++; $display("FAIL wr_side_effects: got k_done=%b en_cycles=%0d need 0 1", od, en);
    end
    run_txn(0, 0, 1, 16'h0010, 16'h1234, r, g, d, en, od, ea, ew, ewe, rd, mv);
    checks++;
    if (d !== r + 2) begin errors++; $display("FAIL wr2_req_to_done: got %0d need 2", d - r); end
  endtask

  task automatic test_core_read();
    int r, g, d, en; bit od, ewe, mv; logic [15:0] ea, ew, rd;
    run_txn(0, 0, 0, 16'h0010, 16'h0000, r, g, d, en, od, ea, ew, ewe, rd, mv);
    checks++;
    if (d !== g + 1 || g !== r + 1) begin
      errors++; $display("FAIL rd1_timing: got grant r+%0d done g+%0d need r+1 g+1", g - r, d - g);
    end
    checks++;
    if (rd !== 16'h1234) begin errors++; $display("FAIL rd1_data: got %h need 1234", rd); end
    checks++;
    if (ewe !== 1'b0 || ea !== 16'h0010 || en !== 1) begin
      errors++; $display("FAIL rd1_ram_ctl: got we=%b addr=%h en_cycles=%0d need 0 0010 1", ewe, ea, en);
    end
    checks++;
    if (c_rdata[0] !== 16'h1234) begin errors++; $display("FAIL rd1_hold: got %h need 1234", c_rdata[0]); end
    run_txn(1, 0, 1, 16'h0010, 16'h1234, r, g, d, en, od, ea, ew, ewe, rd, mv);
    run_txn(1, 0, 0, 16'h0010, 16'h0000, r, g, d, en, od, ea, ew, ewe, rd, mv);
    checks++;
    if (d !== g + 3 || d !== r + 4) begin
      errors++; $display("FAIL rd3_timing: got done g+%0d r+%0d need g+3 r+4", d - g, d - r);
    end
    checks++;
    if (rd !== 16'h1234) begin errors++; $display("FAIL rd3_data: got %h need 1234", rd); end
    checks++;
    if (en !== 1) begin errors++; $display("FAIL rd3_en_cycles: got %0d need 1", en); end
  endtask

  task automatic test_contention();
    int r, last_done, gcyc;
    bit found, exp_k;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    r = cyc; last_done = -1;
    c_req[0] = 1; c_we[0] = 1; c_addr[0] = 16'h0020; c_wdata[0] = 16'h0001;
    k_req[0] = 1; k_we[0] = 1; k_addr[0] = 16'h0021; k_wdata[0] = 16'h00AB;
    for (int t = 0; t < 6; t++) begin
      exp_k = (t % 2) == 1;
      found = 0; gcyc = -1;
      for (int n = 0; n < 10; n++) begin
        @(posedge clk); #1;
        if (ram_en[0]) begin found = 1; gcyc = cyc; break; end
      end
      checks++;
      if (!found || owner[0] !== exp_k) begin
        errors++; $display("FAIL cont_owner[%0d]: got found=%b owner=%b need 1 %b", t, found, owner[0], exp_k);
      end
      checks++;
      if (ram_addr[0] !== (exp_k ? 16'h0021 : 16'h0020) || ram_wdata[0] !== (exp_k ? 16'h00AB : 16'h0001)) begin
        errors++; $display("FAIL cont_bus[%0d]: got %h %h need port %s fields", t, ram_addr[0], ram_wdata[0],
                           exp_k ? "K" : "C");
      end
      checks++;
      if (gcyc !== ((t == 0) ? r + 1 : last_done + 2)) begin
        errors++; $display("FAIL cont_grant_cycle[%0d]: got %0d need %0d", t, gcyc,
                           (t == 0) ? r + 1 : last_done + 2);
      end
      for (int n = 0; n < 10; n++) begin
        @(posedge clk); #1;
        if (c_done[0] || k_done[0]) break;
      end
      checks++;
      if (c_done[0] !== !exp_k || k_done[0] !== exp_k) begin
        errors++; $display("FAIL cont_done[%0d]: got c=%b k=%b need c=%b k=%b", t, c_done[0], k_done[0],
                           !exp_k, exp_k);
      end
      last_done = cyc;
      if (t == 4) c_req[0] = 0;
      if (t == 5) k_req[0] = 0;
    end
    @(posedge clk); #1;
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL cont_idle_after: got busy=%b need 0", busy[0]); end
  endtask

  task automatic test_reset_mid();
    int r, g, d, en; bit od, ewe, mv, seen; logic [15:0] ea, ew, rd;
    run_txn(1, 1, 1, 16'h0040, 16'h7777, r, g, d, en, od, ea, ew, ewe, rd, mv);
    k_req[1] = 1; k_we[1] = 0; k_addr[1] = 16'h0040;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (ram_en[1]) begin seen = 1; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (!seen || busy[1] !== 1'b1 || ram_en[1] !== 1'b0) begin
      errors++; $display("FAIL midrst_in_wait: got grant=%b busy=%b en=%b need 1 1 0", seen, busy[1], ram_en[1]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy[1] !== 1'b0 || ram_en[1] !== 1'b0 || k_done[1] !== 1'b0 || k_rdata[1] !== 16'h0) begin
      errors++; $display("FAIL midrst_outputs: got busy=%b en=%b k_done=%b k_rdata=%h need 0 0 0 0000",
                         busy[1], ram_en[1], k_done[1], k_rdata[1]);
    end
    k_req[1] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      if (k_done[1] || busy[1]) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_quiet: got activity=%b need 0", seen); end
    run_txn(1, 0, 0, 16'h0040, 16'h0000, r, g, d, en, od, ea, ew, ewe, rd, mv);
    checks++;
    if (g !== r + 1 || d !== g + 3 || rd !== 16'h7777) begin
      errors++; $display("FAIL midrst_c_after: got grant r+%0d done g+%0d data %h need r+1 g+3 7777",
                         g - r, d - g, rd);
    end
    checks++;
    if (k_rdata[1] !== 16'h0) begin errors++; $display("FAIL midrst_k_rdata: got %h need 0000", k_rdata[1]); end
  endtask

  task automatic test_rdata_hold();
    int r, g, d, en; bit od, ewe, mv; logic [15:0] ea, ew, rd;
    run_txn(0, 1, 1, 16'h0030, 16'h5555, r, g, d, en, od, ea, ew, ewe, rd, mv);
    run_txn(0, 0, 1, 16'h0031, 16'hAAAA, r, g, d, en, od, ea, ew, ewe, rd, mv);
    run_txn(0, 1, 0, 16'h0030, 16'h0000, r, g, d, en, od, ea, ew, ewe, rd, mv);
    checks++;
    if (rd !== 16'h5555 || d !== g + 1) begin
      errors++; $display("FAIL hold_k_read: got %h at g+%0d need 5555 at g+1", rd, d - g);
    end
    run_txn(0, 0, 0, 16'h0031, 16'h0000, r, g, d, en, od, ea, ew, ewe, rd, mv);
    checks++;
    if (rd !== 16'hAAAA) begin errors++; $display("FAIL hold_c_read: got %h need aaaa", rd); end
    checks++;
    if (mv !== 1'b0 || k_rdata[0] !== 16'h5555) begin
      errors++; $display("FAIL hold_k_stable: got moved=%b k_rdata=%h need 0 5555", mv, k_rdata[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish need finish by 200000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      c_req[i] = 0; c_we[i] = 0; c_addr[i] = '0; c_wdata[i] = '0;
      k_req[i] = 0; k_we[i] = 0; k_addr[i] = '0; k_wdata[i] = '0;
    end
    test_reset();
    test_core_write();
    test_core_read();
    test_contention();
    test_reset_mid();
    test_rdata_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the core's single-port synchronous data RAM between two requesters.
- Port C is the CPU core load/store path. Port K is the PS/2 keyboard scancode writer.
- One transaction runs at a time; the block owns the RAM control pins.
- Round-robin fairness on contention; fixed read latency handled internally.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 16, RAM data width
RD_LAT, 1, RAM read latency in cycles, from the ram_en cycle to valid ram_rdata; legal range 1..4

Ports:
CLOCK_50  in  1  system clock, single clock domain
RESET_N  in  1  asynchronous, active-low reset
c_req  in  1  core request; held until c_done
c_we  in  1  core write enable (1 = write, 0 = read)
c_addr  in  ADDR_W  core address
c_wdata  in  DATA_W  core write data
c_done  out  1  one-cycle completion pulse, core
c_rdata  out  DATA_W  core read data, registered
k_req  in  1  keyboard request
k_we  in  1  keyboard write enable
k_addr  in  ADDR_W  keyboard address
k_wdata  in  DATA_W  keyboard write data
k_done  out  1  one-cycle completion pulse, keyboard
k_rdata  out  DATA_W  keyboard read data, registered
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
busy  out  1  high whenever state != IDLE
owner  out  1  current or most recent grantee: 0 = C, 1 = K

Behaviour:
- Reset (asynchronous, RESET_N = 0):
  - state = IDLE; last_owner = 1, so C wins the first tie.
  - ram_en = ram_we = 0; ram_addr = ram_wdata = 0.
  - c_done = k_done = 0; c_rdata = k_rdata = 0; busy = 0; owner = 1.
- Reset mid-transaction: the in-flight access is abandoned and no done pulse is issued. The requester re-issues after reset.
- All outputs are registered.
- FSM states: IDLE, GRANT, WAIT, DONE.
- IDLE:
  - Samples c_req and k_req.
  - Only one request high: that port is selected.
  - Both high: the port != last_owner is selected.
  - On selection: latch we/addr/wdata into the RAM output registers, set owner and last_owner, go to GRANT.
- GRANT (exactly one cycle):
  - ram_en = 1; ram_we = latched we.
  - Write: go to DONE.
  - Read: load the latency counter with RD_LAT-1. If RD_LAT = 1, go straight to DONE. Otherwise go to WAIT.
- WAIT:
  - ram_en = 0.
  - Counter decrements each cycle; go to DONE when it reaches 0.
- DONE register capture: on entry to DONE (read only), ram_rdata is captured into the owner's rdata register. The other port's rdata is unchanged.
- DONE cycle (one cycle):
  - Owner's done = 1.
  - The owner's rdata holds its value until that port's next read completes.
  - Go to IDLE.
- Latency, with grant cycle g (the first cycle ram_en = 1):
  - Write: done is high in cycle g+1.
  - Read: done is high in cycle g+RD_LAT, and rdata is valid in that same cycle.
  - Best case, request to done: write = 2 cycles, read = RD_LAT+1 cycles.
- Handshake rules:
  - Requester holds req, we, addr and wdata stable from assertion until done.
  - Requester drops req in the cycle after done. A req still high in IDLE after done counts as a new request.
  - Request fields are sampled only in IDLE. Changes during GRANT, WAIT or DONE are ignored.
  - A req dropped before being granted is a protocol violation. The bench flags it; the block's behaviour is unspecified.
- Starvation bound: under continuous contention, grants strictly alternate C, K, C, K.
- Simultaneous done and new request: the other port's req is honoured in the following IDLE cycle. There is no back-to-back grant without an IDLE cycle.
- The counter is 2 bits wide. A parameter check rejects RD_LAT = 0 or RD_LAT > 4 at elaboration.

Decomposition:
- Package ram_arb_pkg:
  - state enum {IDLE, GRANT, WAIT, DONE}
  - OWNER_C = 1'b0, OWNER_K = 1'b1
  - RD_LAT range limits
- One sub-module, arb_rr2: a combinational 2-way round-robin pick. Inputs: req[1:0] and last_owner. Outputs: sel, any.
- The FSM, datapath registers and latency counter stay in ram_port_arbiter.

Test Plan:
- Reset, then a single core write: c_req = 1, c_we = 1, c_addr = 0x0010, c_wdata = 0xBEEF. Expect ram_en = 1 with ram_addr = 0x0010 and ram_wdata = 0xBEEF in cycle g; c_done in cycle g+1; k_done stays 0.
- Core read with RD_LAT = 1, RAM model returning 0x1234 for addr 0x0010. Expect c_done and c_rdata = 0x1234 in cycle g+1. Repeat with RD_LAT = 3: c_done in cycle g+3, and ram_en high in exactly one cycle.
- First cycle after reset, both request: C (write 0x0001 to 0x0020) and K (write 0x00AB to 0x0021). Expect C granted first, K granted second, owner sequence 0 then 1. With both held continuously for 6 transactions, expect grants C, K, C, K, C, K.
- Assert RESET_N = 0 in the WAIT cycle of a K read (RD_LAT = 3). Expect busy = 0 and ram_en = 0 immediately; no k_done; k_rdata = 0. After release, a new C request is granted normally.
- K reads 0x5555 into k_rdata, then C reads 0xAAAA. Expect k_rdata to remain 0x5555 throughout the C transaction.
